// File: rtl/bcd_counter_multi.sv
// N-digit BCD up/down counter with clear, clamped parallel load, wrap or saturate
// at the limits, a combinational terminal count and a sticky overflow flag.
module bcd_counter_multi #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  ovf
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] step_val;
  logic [W-1:0] load_clamped;
  logic         all9;
  logic         all0;

  // Ripple chain: a digit steps only when every lower digit sits at its limit.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    logic [3:0] l;
    step_val     = '0;
    load_clamped = '0;
    all9         = 1'b1;
    all0         = 1'b1;
    carry        = 1'b1;
    d            = '0;
    l            = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = cnt[4*k +: 4];
      l = load_val[4*k +: 4];
      load_clamped[4*k +: 4] = (l > 4'd9) ? 4'd9 : l;
      if (!carry)
        step_val[4*k +: 4] = d;
      else if (up)
        step_val[4*k +: 4] = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      else
        step_val[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
      carry = carry & (up ? (d == 4'd9) : (d == 4'd0));
      all9  = all9 & (d == 4'd9);
      all0  = all0 & (d == 4'd0);
    end
  end

  assign tc = en & ~clear & ~load & ((up & all9) | (~up & all0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= load_clamped;
    end else if (en) begin
      if (tc) begin
        ovf <= 1'b1;
        if (WRAP) cnt <= step_val;
      end else begin
        cnt <= step_val;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench for bcd_counter_multi: three instances (2-digit wrap,
// 2-digit saturate, 1-digit wrap) driven by directed vectors.
module tb_bcd_counter_multi;

  typedef struct {
    int         sel;
    int         id;
    logic       tc;
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       en = 1'b0;
  logic       up = 1'b0;

  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic       tc0, tc1, tc2;
  logic       ovf0, ovf1, ovf2;

  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  exp_t q[$];
  exp_t pend;
  bit   pend_v = 1'b0;

  always #5 clock = ~clock;

  bcd_counter_multi #(.DIGITS(2), .WRAP(1'b1)) u_w (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up), .cnt(cnt0), .tc(tc0), .ovf(ovf0));

  bcd_counter_multi #(.DIGITS(2), .WRAP(1'b0)) u_s (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val), .en(en), .up(up), .cnt(cnt1), .tc(tc1), .ovf(ovf1));

  bcd_counter_multi #(.DIGITS(1), .WRAP(1'b1)) u_d (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_val(load_val[3:0]), .en(en), .up(up), .cnt(cnt2), .tc(tc2), .ovf(ovf2));

  function automatic logic [7:0] get_cnt(int sel);
    case (sel)
      0:       return cnt0;
      1:       return cnt1;
      default: return {4'd0, cnt2};
    endcase
  endfunction

  function automatic logic get_tc(int sel);
    case (sel)
      0:       return tc0;
      1:       return tc1;
      default: return tc2;
    endcase
  endfunction

  function automatic logic get_ovf(int sel);
    case (sel)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic logic [7:0] bcd2(int i);
    return 8'(((i / 10) % 10) * 16 + (i % 10));
  endfunction

  task automatic check(string name, int id, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, req);
    end
  endtask

  // tc is checked at the negedge before the edge; cnt/ovf at the negedge after.
  always @(negedge clock) begin
    if (pend_v) begin
      check("cnt", pend.id, int'(get_cnt(pend.sel)), int'(pend.cnt));
      check("ovf", pend.id, int'(get_ovf(pend.sel)), int'(pend.ovf));
      pend_v = 1'b0;
    end
    if (q.size() > 0) begin
      pend = q.pop_front();
      check("tc", pend.id, int'(get_tc(pend.sel)), int'(pend.tc));
      pend_v = 1'b1;
    end
  end

  task automatic v(input int sel, input logic c, input logic ld, input logic [7:0] lv,
                   input logic e, input logic u, input logic etc,
                   input logic [7:0] ecnt, input logic eovf);
    exp_t x;
    @(posedge clock);
    #1;
    clear = c; load = ld; load_val = lv; en = e; up = u;
    x.sel = sel; x.id = vec_id; x.tc = etc; x.cnt = ecnt; x.ovf = eovf;
    vec_id++;
    q.push_back(x);
  endtask

  task automatic idle_drain();
    int budget;
    @(posedge clock);
    #1;
    clear = 0; load = 0; en = 0; up = 0;
    budget = 0;
    while ((q.size() > 0 || pend_v) && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    @(negedge clock);
    #1;
    checks++;
    if (q.size() > 0 || pend_v) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
  endtask

  initial begin
    // reset state
    #3;
    check("rst_cnt0", -1, int'(cnt0), 0);
    check("rst_ovf0", -1, int'(ovf0), 0);
    check("rst_cnt2", -1, int'(cnt2), 0);
    #9 reset_n = 1'b1;

    // 1: count 00..99 then wrap
    for (int i = 0; i < 100; i++)
      v(0, 0, 0, 8'h00, 1, 1, (i == 99), bcd2((i + 1) % 100), (i == 99));

    // 2: load wins over en, down steps, borrow, idle hold
    v(0, 0, 1, 8'h37, 1, 1, 0, 8'h37, 1);
    v(0, 0, 0, 8'h00, 1, 0, 0, 8'h36, 1);
    v(0, 0, 0, 8'h00, 1, 0, 0, 8'h35, 1);
    v(0, 0, 0, 8'h00, 1, 0, 0, 8'h34, 1);
    v(0, 0, 0, 8'h00, 0, 0, 0, 8'h34, 1);
    v(0, 0, 1, 8'h10, 0, 0, 0, 8'h10, 1);
    v(0, 0, 0, 8'h00, 1, 0, 0, 8'h09, 1);
    v(0, 0, 0, 8'h00, 1, 1, 0, 8'h10, 1);

    // 3: underflow wrap, then clear
    v(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    v(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    v(0, 0, 0, 8'h00, 1, 0, 1, 8'h99, 1);
    v(0, 0, 0, 8'h00, 1, 0, 0, 8'h98, 1);
    v(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);

    // 5: clamp on load, tc masked by load, clear beats load+en
    v(0, 0, 1, 8'hAF, 0, 0, 0, 8'h99, 0);
    v(0, 0, 1, 8'h99, 1, 1, 0, 8'h99, 0);
    v(0, 1, 1, 8'h55, 1, 1, 0, 8'h00, 0);
    v(0, 0, 1, 8'hF3, 0, 0, 0, 8'h93, 0);

    // 4: saturate instance
    v(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    v(1, 0, 1, 8'h98, 0, 0, 0, 8'h98, 0);
    v(1, 0, 0, 8'h00, 1, 1, 0, 8'h99, 0);
    v(1, 0, 0, 8'h00, 1, 1, 1, 8'h99, 1);
    v(1, 0, 0, 8'h00, 1, 0, 0, 8'h98, 1);
    v(1, 0, 1, 8'h01, 0, 0, 0, 8'h01, 1);
    v(1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1);
    v(1, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1);

    // single-digit decade behaviour
    v(2, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++)
      v(2, 0, 0, 8'h00, 1, 1, (i == 9), 8'((i + 1) % 10), (i == 9));
    v(2, 0, 1, 8'h0F, 0, 0, 0, 8'h09, 1);
    v(2, 0, 0, 8'h00, 1, 0, 0, 8'h08, 1);

    // 6: async reset between edges at 57 with ovf set
    v(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0);
    v(0, 0, 0, 8'h00, 1, 0, 1, 8'h99, 1);
    v(0, 0, 1, 8'h57, 0, 0, 0, 8'h57, 1);
    idle_drain();
    reset_n = 1'b0;
    #1;
    check("arst_cnt", -2, int'(cnt0), 0);
    check("arst_ovf", -2, int'(ovf0), 0);
    #1 reset_n = 1'b1;
    v(0, 0, 0, 8'h00, 1, 1, 0, 8'h01, 0);
    idle_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
